// File: rtl/ioctl_rom_router_if.sv
// Host download bus into the router plus the ROM write port it drives toward the game core.
interface ioctl_rom_router_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/ioctl_rom_router.sv
// Routes host download streams: index 0 to the ROM write port, 1 to the variant byte, 254 to DIP bytes.
// Holds the game core in reset from download start until HOLD_CYCLES after the ROM stream ends.
module ioctl_rom_router #(
  parameter int HOLD_CYCLES = 64,
  parameter int MIN_BYTES   = 16384
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  ioctl_rom_router_if.slave    bus,
  output logic [7:0]           mod,
  output logic [7:0]           sw0,
  output logic [7:0]           sw1,
  output logic [7:0]           sw2,
  output logic [7:0]           sw3,
  output logic                 core_reset,
  output logic                 rom_valid,
  output logic [16:0]          byte_count,
  output logic                 overflow
);

  localparam int          HCW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [16:0] MIN_B = 17'(MIN_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t           state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;

  logic             dn_wr_q, dn_wr_d;
  logic [15:0]      dn_addr_q, dn_addr_d;
  logic [7:0]       dn_data_q, dn_data_d;
  logic [16:0]      byte_count_q, byte_count_d;
  logic             overflow_q, overflow_d;
  logic             rom_valid_q, rom_valid_d;
  logic [7:0]       mod_q, mod_d;
  logic [3:0][7:0]  sw_q, sw_d;

  logic start, rom_wr, accept, high_addr;

  assign start     = bus.ioctl_download && (bus.ioctl_index == 8'd0);
  assign high_addr = |bus.ioctl_addr[24:16];
  // ROM bytes count only inside LOAD with the download still asserted
  assign rom_wr    = (state_q == LOAD) && start && bus.ioctl_wr;
  assign accept    = rom_wr && !high_addr;

  // state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, RUN: if (start) state_d = LOAD;
      LOAD: begin
        if (!bus.ioctl_download) begin
          state_d = HOLD;
          hold_d  = HCW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (start)              state_d = LOAD;
        else if (hold_q == '0)  state_d = RUN;
        else                    hold_d  = hold_q - HCW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    core_reset = (state_q != RUN);
  end

  always_comb begin
    dn_wr_d      = 1'b0;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    rom_valid_d  = rom_valid_q;
    mod_d        = mod_q;
    sw_d         = sw_q;

    if (state_d == LOAD && state_q != LOAD) begin
      byte_count_d = '0;
      overflow_d   = 1'b0;
      rom_valid_d  = 1'b0;
    end

    if (accept) begin
      dn_wr_d   = 1'b1;
      dn_addr_d = bus.ioctl_addr[15:0];
      dn_data_d = bus.ioctl_dout;
      if (byte_count_q != 17'h1FFFF) byte_count_d = byte_count_q + 17'd1;
    end
    if (rom_wr && high_addr) overflow_d = 1'b1;

    // verdict uses the post-write count so a byte on the final LOAD cycle is included
    if (state_q == LOAD && state_d == HOLD)
      rom_valid_d = (byte_count_d >= MIN_B) && !overflow_d;

    if (bus.ioctl_wr && bus.ioctl_index == 8'd1) mod_d = bus.ioctl_dout;
    if (bus.ioctl_wr && bus.ioctl_index == 8'd254 && bus.ioctl_addr[24:2] == '0)
      sw_d[bus.ioctl_addr[1:0]] = bus.ioctl_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      rom_valid_q  <= 1'b0;
      mod_q        <= '0;
      sw_q         <= {4{8'hFF}};
    end else begin
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      rom_valid_q  <= rom_valid_d;
      mod_q        <= mod_d;
      sw_q         <= sw_d;
    end
  end

  assign bus.dn_wr   = dn_wr_q;
  assign bus.dn_addr = dn_addr_q;
  assign bus.dn_data = dn_data_q;
  assign byte_count  = byte_count_q;
  assign overflow    = overflow_q;
  assign rom_valid   = rom_valid_q;
  assign mod         = mod_q;
  assign sw0         = sw_q[0];
  assign sw1         = sw_q[1];
  assign sw2         = sw_q[2];
  assign sw3         = sw_q[3];

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed sequence of download scenarios with randomized bytes, checked against expectations from the rules.
module tb_ioctl_rom_router;
  localparam int HOLD = 64;
  localparam int MINB = 16384;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  mod, sw0, sw1, sw2, sw3;
  logic        core_reset, rom_valid, overflow;
  logic [16:0] byte_count;

  ioctl_rom_router_if bus();

  ioctl_rom_router #(.HOLD_CYCLES(HOLD), .MIN_BYTES(MINB)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .mod(mod), .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .core_reset(core_reset), .rom_valid(rom_valid),
    .byte_count(byte_count), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_a = '0;
  logic [7:0]  last_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic dl, input logic [7:0] idx, input logic wr,
                     input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_download = dl;
    bus.ioctl_index    = idx;
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = a;
    bus.ioctl_dout     = d;
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic begin_load;
    drv(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
    tick;
    chk("enter_byte_count", byte_count, 0);
    chk("enter_overflow", overflow, 0);
    chk("enter_rom_valid", rom_valid, 0);
    chk("enter_core_reset", core_reset, 1);
  endtask

  task automatic write_bytes(input int n, input bit rnd_addr, input bit rnd_data);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = rnd_addr ? 16'($urandom) : 16'(i);
      d = rnd_data ? 8'($urandom) : a[7:0];
      if ($urandom_range(0, 15) == 0) begin
        drv(1'b1, 8'd0, 1'b0, {9'd0, a ^ 16'h5a5a}, ~d);
        tick;
        chk("gap_dn_wr", bus.dn_wr, 0);
        chk("gap_dn_addr", bus.dn_addr, last_a);
        chk("gap_dn_data", bus.dn_data, last_d);
      end
      drv(1'b1, 8'd0, 1'b1, {9'd0, a}, d);
      tick;
      chk("dn_wr", bus.dn_wr, 1);
      chk("dn_addr", bus.dn_addr, a);
      chk("dn_data", bus.dn_data, d);
      last_a = a;
      last_d = d;
    end
    drv(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
  endtask

  task automatic end_load(input int exp_cnt, input bit exp_ovf);
    int edges;
    // the download drops together with a write strobe, which must not land
    drv(1'b0, 8'd0, 1'b1, 25'h00123, 8'hA5);
    tick;
    chk("drop_dn_wr", bus.dn_wr, 0);
    chk("final_byte_count", byte_count, exp_cnt);
    chk("final_overflow", overflow, exp_ovf);
    chk("rom_valid", rom_valid, (exp_cnt >= MINB) && !exp_ovf);
    drv(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    edges = 1;
    while (core_reset === 1'b1 && edges < 4 * HOLD) begin
      tick;
      edges++;
    end
    chk("hold_cycles", edges - 1, HOLD);
    chk("run_core_reset", core_reset, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] swv [5];
    swv[0] = 8'h11; swv[1] = 8'h22; swv[2] = 8'h33; swv[3] = 8'h44; swv[4] = 8'h55;

    reset = 1'b1;
    drv(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    repeat (3) tick;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_dn_wr", bus.dn_wr, 0);
    chk("rst_dn_addr", bus.dn_addr, 0);
    chk("rst_dn_data", bus.dn_data, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rom_valid", rom_valid, 0);
    chk("rst_mod", mod, 0);
    chk("rst_sw", {sw3, sw2, sw1, sw0}, 32'hFFFF_FFFF);
    reset = 1'b0;
    tick;
    chk("idle_core_reset", core_reset, 1);

    // full-size ROM with data = low address byte
    begin_load;
    write_bytes(MINB, 1'b0, 1'b0);
    end_load(MINB, 1'b0);

    // short ROM, random addresses and data: invalid but still runs
    begin_load;
    write_bytes(100, 1'b1, 1'b1);
    end_load(100, 1'b0);

    // side streams while the core runs
    drv(1'b1, 8'd1, 1'b1, 25'h01234, 8'h0B);
    tick;
    chk("mod_latch", mod, 8'h0B);
    chk("mod_core_reset", core_reset, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'd254, 1'b1, 25'(i), swv[i]);
      tick;
      chk("sw_core_reset", core_reset, 0);
    end
    drv(1'b1, 8'd7, 1'b1, 25'd0, 8'($urandom));
    tick;
    drv(1'b0, 8'd0, 1'b1, 25'h00042, 8'h99);
    tick;
    chk("stray_rom_dn_wr", bus.dn_wr, 0);
    chk("stray_rom_byte_count", byte_count, 100);
    drv(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    tick;
    chk("mod_final", mod, 8'h0B);
    chk("sw0", sw0, 8'h11);
    chk("sw1", sw1, 8'h22);
    chk("sw2", sw2, 8'h33);
    chk("sw3", sw3, 8'h44);
    chk("side_core_reset", core_reset, 0);
    chk("side_rom_valid", rom_valid, 0);

    // full ROM followed by an out-of-range byte
    begin_load;
    write_bytes(MINB, 1'b0, 1'b1);
    drv(1'b1, 8'd0, 1'b1, 25'h10000, 8'($urandom));
    tick;
    chk("ovf_dn_wr", bus.dn_wr, 0);
    chk("ovf_dn_addr", bus.dn_addr, last_a);
    chk("ovf_flag", overflow, 1);
    end_load(MINB, 1'b1);

    // one byte short of the minimum
    begin_load;
    write_bytes(MINB - 1, 1'b0, 1'b1);
    end_load(MINB - 1, 1'b0);

    // restart while holding
    begin_load;
    write_bytes(20, 1'b1, 1'b1);
    drv(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_core_reset", core_reset, 1);
    end
    begin_load;
    write_bytes(30, 1'b1, 1'b1);
    end_load(30, 1'b0);

    // reset in the middle of a load, with a write on the reset cycle
    begin_load;
    write_bytes(50, 1'b1, 1'b1);
    reset = 1'b1;
    drv(1'b1, 8'd0, 1'b1, 25'd50, 8'h77);
    tick;
    chk("midrst_dn_wr", bus.dn_wr, 0);
    chk("midrst_dn_addr", bus.dn_addr, 0);
    chk("midrst_byte_count", byte_count, 0);
    chk("midrst_sw", {sw3, sw2, sw1, sw0}, 32'hFFFF_FFFF);
    chk("midrst_mod", mod, 0);
    chk("midrst_core_reset", core_reset, 1);
    last_a = '0;
    last_d = '0;
    reset = 1'b0;
    drv(1'b0, 8'd0, 1'b1, 25'd51, 8'h78);
    for (int i = 0; i < 100; i++) begin
      tick;
      chk("postrst_core_reset", core_reset, 1);
      chk("postrst_dn_wr", bus.dn_wr, 0);
    end
    chk("postrst_byte_count", byte_count, 0);
    begin_load;
    write_bytes(5, 1'b1, 1'b1);
    end_load(5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ioctl_rom_router.md
IOCTL_ROM_ROUTER -- requirements
Module: ioctl_rom_router

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 64: clock cycles core_reset stays high after a ROM download ends.
REQ-002 SHALL have parameter MIN_BYTES, default 16384: minimum accepted ROM byte count for rom_valid.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1, high while a download from the host interface is in progress.
REQ-006 SHALL have port ioctl_index, input, 8, selects the download stream: 0 ROM, 1 mod byte, 254 DIP bytes.
REQ-007 SHALL have ports ioctl_wr (input, 1, byte strobe), ioctl_addr (input, 25, byte address) and ioctl_dout (input, 8, byte data).
REQ-008 SHALL have ports dn_addr (output, 16), dn_data (output, 8) and dn_wr (output, 1), forming the ROM write port to the game core.
REQ-009 SHALL have port mod, output, 8, the captured game-variant byte.
REQ-010 SHALL have ports sw0, sw1, sw2, sw3, each output, 8, the captured DIP/input-mask bytes.
REQ-011 SHALL have port core_reset, output, 1, the reset request to the game core.
REQ-012 SHALL have port rom_valid, output, 1, high when the last ROM load completed with at least MIN_BYTES bytes.
REQ-013 SHALL have port byte_count, output, 17, the number of ROM bytes accepted in the current or last load.
REQ-014 SHALL have port overflow, output, 1, sticky flag set when a ROM byte address is 65536 or higher.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, HOLD and RUN; it SHALL enter IDLE from reset.
REQ-016 IDLE->LOAD and RUN->LOAD SHALL occur on a cycle with ioctl_download=1 and ioctl_index=0; HOLD->LOAD SHALL occur on the same condition.
REQ-017 On entering LOAD, byte_count SHALL clear to 0, and overflow and rom_valid SHALL clear to 0.
REQ-018 LOAD->HOLD SHALL occur on the first cycle with ioctl_download=0; the hold counter SHALL load HOLD_CYCLES-1.
REQ-019 In HOLD the hold counter SHALL decrement each cycle; at 0 the FSM SHALL go to RUN, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-020 core_reset SHALL be high in IDLE, LOAD and HOLD and low only in RUN.
REQ-021 In LOAD, a cycle with ioctl_wr=1 and ioctl_addr<65536 SHALL produce dn_wr=1 one cycle later, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout, and SHALL increment byte_count (saturating at 131071).
REQ-022 In LOAD, a cycle with ioctl_wr=1 and ioctl_addr>=65536 SHALL NOT pulse dn_wr and SHALL set overflow.
REQ-023 dn_wr SHALL be a single-cycle pulse per accepted byte; dn_addr and dn_data SHALL hold their last values while dn_wr=0.
REQ-024 On the LOAD->HOLD transition, rom_valid SHALL be set if and only if byte_count>=MIN_BYTES and overflow=0, counting a write accepted on that same final cycle.
REQ-025 A write with ioctl_index=1 SHALL latch mod=ioctl_dout in any state, regardless of ioctl_addr; it SHALL NOT change the FSM state.
REQ-026 A write with ioctl_index=254 and ioctl_addr<4 SHALL latch ioctl_dout into sw[ioctl_addr[1:0]]; writes at addresses 4 and above SHALL be ignored.
REQ-027 Writes with any other index SHALL be ignored entirely.
REQ-028 An index-0 write outside LOAD (ioctl_download=0) SHALL be ignored.
REQ-029 If ioctl_download drops on the same cycle as ioctl_wr, the write SHALL still be ignored, because LOAD requires ioctl_download=1.
REQ-030 If ROM loading does not complete with rom_valid=1, the FSM SHALL still reach RUN; gating on rom_valid is the top level's responsibility.

Reset
REQ-031 On reset the block SHALL set: state=IDLE, core_reset=1, dn_wr=0, dn_addr=0, dn_data=0, byte_count=0, overflow=0, rom_valid=0, mod=0, sw0..sw3=8'hFF.
REQ-032 Reset asserted mid-LOAD SHALL abort the load with no further dn_wr; after release the FSM SHALL stay in IDLE until a new index-0 download starts.
REQ-033 Reset SHALL take priority over all simultaneous ioctl activity.

Verification
REQ-034 Load 16384 index-0 bytes at addresses 0..16383 with data=addr[7:0] -> 16384 dn_wr pulses, each 1 cycle late with matching addr/data; byte_count=16384; rom_valid=1; core_reset falls exactly 64 cycles after ioctl_download falls.
REQ-035 Load 100 bytes -> rom_valid=0, byte_count=100, FSM still reaches RUN after 64 cycles.
REQ-036 Load 16384 bytes plus one write at address 0x10000 -> no dn_wr for that byte; overflow=1; rom_valid=0.
REQ-037 Index-1 write of 0x0B, then index-254 writes 0x11,0x22,0x33,0x44,0x55 at addresses 0..4 -> mod=0x0B; sw0..sw3=11,22,33,44; the address-4 byte is ignored; core_reset is unchanged.
REQ-038 Assert reset after 50 ROM bytes -> no dn_wr after reset; byte_count=0; sw0..sw3=FF; core_reset stays 1 until the next completed load.
REQ-039 Start a new index-0 download while in HOLD -> FSM returns to LOAD, byte_count restarts at 0, core_reset never deasserts in between.
